// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared LPC cycle encodings and capture record layout
package lpc_pkg;

    localparam int REC_BYTES = 6;
    localparam int REC_BITS  = REC_BYTES * 8;

    typedef enum logic [3:0] {
        CYC_IO_RD  = 4'b0000,
        CYC_IO_WR  = 4'b0010,
        CYC_MEM_RD = 4'b0100,
        CYC_MEM_WR = 4'b0110,
        CYC_DMA_RD = 4'b1000,
        CYC_DMA_WR = 4'b1010
    } lpc_cyctype_e;

    typedef struct packed {
        logic [3:0]  cyctype_dir;
        logic [2:0]  data_size;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        lost;
    } lpc_rec_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_e;

    // Wire order, MSB first: header {cyctype_dir, lost, data_size}, addr, data.
    function automatic logic [REC_BITS-1:0] rec_serialize(input lpc_rec_t r);
        return {r.cyctype_dir, r.lost, r.data_size, r.addr, r.data};
    endfunction

endpackage

// File: rtl/lpc_capture_sched_if.sv
// rtl/lpc_capture_sched_if.sv - serialized record byte stream
interface lpc_capture_sched_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/lpc_rec_fifo.sv
// rtl/lpc_rec_fifo.sv - synchronous show-ahead FIFO of capture records
module lpc_rec_fifo
    import lpc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   lpc_clock,
    input  logic                   lpc_reset,
    input  logic                   push,
    input  lpc_rec_t               wdata,
    input  logic                   pop,
    output lpc_rec_t               rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    lpc_rec_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_en;
    logic            rd_en;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge lpc_clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lpc_capture_sched.sv
// rtl/lpc_capture_sched.sv - filters decoded LPC cycles into a record FIFO and serializes them as bytes
module lpc_capture_sched
    import lpc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   lpc_clock,
    input  logic                   lpc_reset,
    input  logic [3:0]             in_cyctype_dir,
    input  logic [31:0]            in_addr,
    input  logic [31:0]            in_data,
    input  logic [2:0]             in_data_size,
    input  logic                   in_valid,
    input  logic                   capture_en,
    input  logic [7:0]             cfg_type_mask,
    lpc_capture_sched_if.master    tx,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_count
);

    tx_state_e             state;
    tx_state_e             state_next;
    logic                  pop;
    logic                  load;
    logic                  shift;

    logic                  accept;
    logic                  store;
    logic                  drop;
    logic                  lost_flag;
    logic                  fifo_full;
    logic                  fifo_empty;
    lpc_rec_t              wrec;
    lpc_rec_t              head;
    logic [REC_BITS-1:0]   shreg;
    logic [2:0]            byte_idx;
    logic                  unused_data;

    assign unused_data = ^in_data[31:8];

    assign accept = in_valid && capture_en && cfg_type_mask[in_cyctype_dir[3:1]];
    assign store  = accept && (!fifo_full || pop);
    assign drop   = accept && !store;

    assign wrec = '{
        cyctype_dir: in_cyctype_dir,
        data_size:   in_data_size,
        addr:        in_addr,
        data:        in_data[7:0],
        lost:        lost_flag
    };

    lpc_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .lpc_clock (lpc_clock),
        .lpc_reset (lpc_reset),
        .push      (store),
        .wdata     (wrec),
        .pop       (pop),
        .rdata     (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx.tx_ready) begin
                    shift = 1'b1;
                    if (byte_idx == 3'(REC_BYTES - 1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Zeros shift in behind the record, so tx_data returns to 0x00 once a record is fully sent.
    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            shreg    <= rec_serialize(head);
            byte_idx <= '0;
        end else if (shift) begin
            shreg    <= {shreg[REC_BITS-9:0], 8'h00};
            byte_idx <= byte_idx + 1'b1;
        end
    end

    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            lost_flag  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop) begin
                lost_flag <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end else if (store) begin
                lost_flag <= 1'b0;
            end
        end
    end

    assign tx.tx_valid = (state == ST_SEND);
    assign tx.tx_data  = shreg[REC_BITS-1 -: 8];

endmodule

// File: doc/lpc_capture_sched.md
LPC_CAPTURE_SCHED -- requirements
Module: lpc_capture_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, record FIFO depth in records (power of two, 2..64).
REQ-002 SHALL have port lpc_clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port lpc_reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_cyctype_dir  in  4  decoded cycle type/direction from the LPC decoder.
REQ-005 SHALL have port in_addr  in  32  decoded cycle address.
REQ-006 SHALL have port in_data  in  32  decoded cycle data; only bits [7:0] are used.
REQ-007 SHALL have port in_data_size  in  3  decoded data size.
REQ-008 SHALL have port in_valid  in  1  one-cycle strobe; in_* fields are valid this cycle (decoder out_clock_enable).
REQ-009 SHALL have port capture_en  in  1  global capture enable.
REQ-010 SHALL have port cfg_type_mask  in  8  per-class enable, indexed by in_cyctype_dir[3:1].
REQ-011 SHALL have port tx_data  out  8  serialized record byte.
REQ-012 SHALL have port tx_valid  out  1  tx_data valid.
REQ-013 SHALL have port tx_ready  in  1  sink accepts tx_data.
REQ-014 SHALL have port fifo_level  out  $clog2(DEPTH)+1  records currently stored.
REQ-015 SHALL have port drop_count  out  8  dropped-record counter, saturating.

Function
REQ-016 SHALL accept a record when in_valid=1, capture_en=1 and cfg_type_mask[in_cyctype_dir[3:1]]=1; otherwise the strobe is ignored and causes no side effects.
REQ-017 SHALL store an accepted record {cyctype_dir, data_size, addr[31:0], data[7:0], lost} in the FIFO when not full, or when full and a pop occurs in the same cycle.
REQ-018 SHALL, when an accepted record cannot be stored, drop it, increment drop_count (saturating at 255) and set an internal lost flag.
REQ-019 SHALL copy the lost flag into the next stored record and clear the flag in that same cycle.
REQ-020 SHALL serialize each record as 6 bytes, MSB first: header {cyctype_dir[3:0], lost, data_size[2:0]}, addr[31:24], addr[23:16], addr[15:8], addr[7:0], data[7:0].
REQ-021 SHALL implement FSM IDLE/SEND: IDLE with FIFO non-empty pops one record into a shift register and enters SEND with byte index 0; SEND advances the index on each cycle with tx_valid=1 and tx_ready=1; after byte 5 transfers, it returns to IDLE.
REQ-022 SHALL assert tx_valid only in SEND and hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-023 SHALL, from an empty FIFO and IDLE state, assert tx_valid with the header byte in the cycle after the second rising edge following the in_valid cycle.
REQ-024 SHALL insert exactly one IDLE cycle between consecutive records.
REQ-025 SHALL let deassertion of capture_en block new pushes only; records already stored and the record in flight SHALL still be transmitted completely.
REQ-026 SHALL let cfg_type_mask changes take effect on the next in_valid.
REQ-027 SHALL keep fifo_level equal to pushes minus pops, with simultaneous push and pop leaving it unchanged.

Reset
REQ-028 SHALL, while lpc_reset=1 at a clock edge, empty the FIFO, enter IDLE, clear the lost flag and drive tx_valid=0, tx_data=0x00, fifo_level=0, drop_count=0.
REQ-029 SHALL discard a partially sent record on reset mid-SEND; no remaining bytes are emitted.

Structure
REQ-030 SHALL take cycle-type encodings, REC_BYTES=6 and the record field layout from shared package lpc_pkg.
REQ-031 SHALL instantiate the record storage as sub-module lpc_rec_fifo: a synchronous FIFO, DEPTH-parameterized, with full/empty/level outputs.

Verification
REQ-032 SHALL cover: IO read cyctype_dir=0000, addr=0x7fe5, data=0x6c, size=1, mask=0xFF, tx_ready=1 -> bytes 01 00 00 7F E5 6C, first byte two edges after in_valid.
REQ-033 SHALL cover: tx_ready held 0 for 5 cycles during byte 2 -> tx_data stays 0x00 and tx_valid stays 1; the sequence then completes unchanged.
REQ-034 SHALL cover: tx_ready=0 with DEPTH+3 accepted strobes -> fifo_level=DEPTH, drop_count=2 (one record is in the shift register), and the next stored record's header bit3=1.
REQ-035 SHALL cover: cfg_type_mask=0xFE with cycles of cyctype_dir 0000 and 0010 -> only the 0010 record is emitted (header 0x21 for size 1).
REQ-036 SHALL cover: lpc_reset asserted after byte 3 of a record with 2 records queued -> tx_valid=0 the next cycle, fifo_level=0, and no further bytes are emitted.
REQ-037 SHALL cover: 300 drops -> drop_count saturates at 255.
